// File: rtl/tinyml_load_pkg.sv
// Shared types and sizing helpers for the tile loader: FSM state encoding,
// beats-per-tile and tiles-per-row arithmetic.
package tinyml_load_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRIME  = 3'd1,
        ST_READ   = 3'd2,
        ST_OUTPUT = 3'd3,
        ST_DONE   = 3'd4
    } load_state_e;

    function automatic int calc_beats(input int tile_width, input int bus_bytes);
        return tile_width / (bus_bytes * 8);
    endfunction

    // Ceiling division; row_bytes stays below 2^23, so the sum cannot overflow.
    function automatic logic [31:0] calc_tiles(input logic [31:0] row_bytes,
                                               input int tile_bytes);
        return (row_bytes + 32'(tile_bytes) - 32'd1) / 32'(tile_bytes);
    endfunction

endpackage

// File: rtl/tile_packer.sv
// Inserts one memory beat into the tile register. Bytes past the end of the row
// are zero-filled, and the lowest-address byte of each beat goes most significant.
module tile_packer
    import tinyml_load_pkg::*;
#(
    parameter int TILE_WIDTH = 256,
    parameter int BUS_BYTES  = 4,
    parameter int CW         = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cap_en,
    input  logic [CW-1:0]           cap_idx,
    input  logic [31:0]             beat_off,
    input  logic [31:0]             row_bytes,
    input  logic [BUS_BYTES*8-1:0]  mem_rdata,
    output logic [TILE_WIDTH-1:0]   tile_data
);

    localparam int BUS_W = BUS_BYTES * 8;

    logic [BUS_W-1:0] masked;

    // mem_rdata carries the byte at the beat address in lane 0 (bits 7:0).
    always_comb begin
        masked = '0;
        for (int i = 0; i < BUS_BYTES; i++) begin
            if (beat_off + 32'(i) < row_bytes) begin
                masked[BUS_W-1-8*i -: 8] = mem_rdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile_data <= '0;
        end else if (cap_en) begin
            tile_data[TILE_WIDTH-1-int'(cap_idx)*BUS_W -: BUS_W] <= masked;
        end
    end

endmodule

// File: rtl/tile_loader.sv
// Walks a strided 2-D region of external memory and emits it as fixed-width
// tiles, one row at a time, zero-filling past the end of each row.
module tile_loader
    import tinyml_load_pkg::*;
#(
    parameter int TILE_WIDTH = 256,
    parameter int DATA_WIDTH = 8,
    parameter int BUS_BYTES  = 4,
    parameter int ADDR_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [19:0]             cmd_length,
    input  logic [11:0]             cmd_rows,
    input  logic [ADDR_WIDTH-1:0]   cmd_stride,
    input  logic                    abort,
    output logic                    mem_rd_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [BUS_BYTES*8-1:0]  mem_rdata,
    output logic [TILE_WIDTH-1:0]   tile_data,
    output logic                    tile_valid,
    input  logic                    tile_ready,
    output logic                    tile_last,
    output logic                    done,
    output logic                    busy,
    output load_state_e             dbg_state
);

    localparam int BEATS      = calc_beats(TILE_WIDTH, BUS_BYTES);
    localparam int TILE_BYTES = TILE_WIDTH / 8;
    localparam int CW         = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BUS_BYTES - 1);

    load_state_e           state, state_n;
    logic [ADDR_WIDTH-1:0] rd_addr, row_base, stride_q;
    logic [11:0]           rows_q, row_cnt;
    logic [31:0]           row_bytes, tiles_q, tile_cnt, tile_off;
    logic [CW-1:0]         cap_cnt;
    logic                  cap_en, accept, out_hs;
    logic                  last_tile_of_row, last_row;
    logic [31:0]           row_bytes_in;

    // Handshakes: a transfer happens on a rising clk edge where valid and ready
    // are both high; the offering side holds its payload stable until then.
    assign accept           = (state == ST_IDLE) && cmd_valid;
    assign out_hs           = (state == ST_OUTPUT) && tile_ready && !abort;
    assign last_tile_of_row = (tile_cnt == tiles_q - 32'd1);
    assign last_row         = (row_cnt == rows_q - 12'd1);
    assign row_bytes_in     = 32'(cmd_length) * 32'(DATA_WIDTH / 8);

    always_comb begin
        state_n   = state;
        mem_rd_en = 1'b0;
        cap_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_n = (cmd_length == '0 || cmd_rows == '0) ? ST_DONE : ST_PRIME;
                end
            end
            ST_PRIME: begin
                mem_rd_en = 1'b1;
                state_n   = ST_READ;
            end
            ST_READ: begin
                cap_en = 1'b1;
                if (cap_cnt == CW'(BEATS - 1)) begin
                    state_n = ST_OUTPUT;
                end else begin
                    mem_rd_en = 1'b1;
                end
            end
            ST_OUTPUT: begin
                if (tile_ready) begin
                    state_n = (last_tile_of_row && last_row) ? ST_DONE : ST_PRIME;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        // Abort wins over everything, including a same-cycle tile handshake.
        if (abort && state != ST_IDLE) begin
            state_n   = ST_IDLE;
            mem_rd_en = 1'b0;
            cap_en    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rd_addr   <= '0;
            row_base  <= '0;
            stride_q  <= '0;
            rows_q    <= '0;
            row_cnt   <= '0;
            row_bytes <= '0;
            tiles_q   <= '0;
            tile_cnt  <= '0;
            tile_off  <= '0;
            cap_cnt   <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                rd_addr   <= cmd_addr & ALIGN_MASK;
                row_base  <= cmd_addr & ALIGN_MASK;
                stride_q  <= cmd_stride & ALIGN_MASK;
                rows_q    <= cmd_rows;
                row_cnt   <= '0;
                row_bytes <= row_bytes_in;
                tiles_q   <= calc_tiles(row_bytes_in, TILE_BYTES);
                tile_cnt  <= '0;
                tile_off  <= '0;
            end
            if (mem_rd_en) begin
                rd_addr <= rd_addr + ADDR_WIDTH'(BUS_BYTES);
            end
            if (state == ST_PRIME) begin
                cap_cnt <= '0;
            end else if (cap_en) begin
                cap_cnt <= cap_cnt + CW'(1);
            end
            // Within a row rd_addr already points at the next tile; a new row
            // restarts from the previous row base plus stride.
            if (out_hs && !(last_tile_of_row && last_row)) begin
                if (last_tile_of_row) begin
                    row_base <= row_base + stride_q;
                    rd_addr  <= row_base + stride_q;
                    row_cnt  <= row_cnt + 12'd1;
                    tile_cnt <= '0;
                    tile_off <= '0;
                end else begin
                    tile_cnt <= tile_cnt + 32'd1;
                    tile_off <= tile_off + 32'(TILE_BYTES);
                end
            end
        end
    end

    tile_packer #(
        .TILE_WIDTH (TILE_WIDTH),
        .BUS_BYTES  (BUS_BYTES),
        .CW         (CW)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .cap_en    (cap_en),
        .cap_idx   (cap_cnt),
        .beat_off  (tile_off + 32'(cap_cnt) * 32'(BUS_BYTES)),
        .row_bytes (row_bytes),
        .mem_rdata (mem_rdata),
        .tile_data (tile_data)
    );

    assign mem_addr   = rd_addr;
    assign cmd_ready  = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign tile_valid = (state == ST_OUTPUT);
    assign tile_last  = (state == ST_OUTPUT) && last_tile_of_row && last_row;
    assign done       = (state == ST_DONE) && !abort;
    assign dbg_state  = state;

endmodule

// File: tb/tb_tile_loader.sv
// Directed bench for tile_loader with a byte-at-A-equals-A[7:0] memory model.
module tb_tile_loader;
    import tinyml_load_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [23:0] cmd_addr = '0;
    logic [19:0] cmd_length = '0;
    logic [11:0] cmd_rows = '0;
    logic [23:0] cmd_stride = '0;
    logic        abort = 1'b0;
    logic        mem_rd_en;
    logic [23:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic [255:0] tile_data;
    logic        tile_valid;
    logic        tile_ready = 1'b1;
    logic        tile_last;
    logic        done;
    logic        busy;
    load_state_e dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int rd_count = 0;
    int done_count = 0;
    int tv_count = 0;

    tile_loader dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_length(cmd_length), .cmd_rows(cmd_rows),
        .cmd_stride(cmd_stride), .abort(abort), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .tile_data(tile_data),
        .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_last(tile_last),
        .done(done), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Memory: read data for mem_addr appears one cycle later, byte A in lane A%4.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            for (int i = 0; i < 4; i++) mem_rdata[8*i +: 8] <= mem_addr[7:0] + 8'(i);
        end
        if (mem_rd_en) rd_count++;
        if (done) done_count++;
        if (tile_valid) tv_count++;
    end

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [255:0] make_tile(input int base, input int nvalid);
        logic [255:0] t;
        t = '0;
        for (int j = 0; j < 32; j++) begin
            if (j < nvalid) t[255-8*j -: 8] = 8'(base + j);
        end
        return t;
    endfunction

    task automatic send_cmd(input int addr, input int len, input int rows, input int stride);
        @(negedge clk);
        cmd_addr = 24'(addr); cmd_length = 20'(len); cmd_rows = 12'(rows);
        cmd_stride = 24'(stride); cmd_valid = 1'b1;
        check("cmd_ready_idle", 256'(cmd_ready), 256'(1));
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_tile(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tile_valid && n < 100);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 256'(busy), 256'(0));
    endtask

    int n;
    int rd0, dn0, tv0;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 256'(cmd_ready), 256'(1));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_outputs", {tile_valid, tile_last, done, mem_rd_en}, 256'(0));
        check("rst_mem_addr", 256'(mem_addr), 256'(0));
        check("rst_tile_data", tile_data, 256'(0));
        rst = 1'b0;

        // Single full tile
        rd0 = rd_count;
        send_cmd(32'h100, 32, 1, 0);
        @(negedge clk);
        check("prime_rd_en", 256'(mem_rd_en), 256'(1));
        check("prime_addr", 256'(mem_addr), 256'(24'h100));
        wait_tile(n);
        check("t1_latency", 256'(n + 1), 256'(10));
        check("t1_data", tile_data, make_tile(32'h100, 32));
        check("t1_last", 256'(tile_last), 256'(1));
        @(negedge clk);
        check("t1_done", 256'(done), 256'(1));
        @(negedge clk);
        check("t1_done_once", {done, busy}, 256'(0));
        check("t1_reads", 256'(rd_count - rd0), 256'(8));

        // Row of 40 bytes -> two tiles, second zero-filled past byte 8
        send_cmd(0, 40, 1, 0);
        wait_tile(n);
        check("t2a_latency", 256'(n), 256'(10));
        check("t2a_data", tile_data, make_tile(0, 32));
        check("t2a_last", 256'(tile_last), 256'(0));
        wait_tile(n);
        check("t2b_spacing", 256'(n), 256'(10));
        check("t2b_data", tile_data, make_tile(32'h20, 8));
        check("t2b_last", 256'(tile_last), 256'(1));
        wait_idle();

        // Three short rows with stride, plus a command offered while busy
        send_cmd(32'h100, 16, 3, 32'h40);
        @(negedge clk);
        cmd_addr = 24'h800; cmd_valid = 1'b1;
        #1 check("busy_cmd_ready", 256'(cmd_ready), 256'(0));
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int r = 0; r < 3; r++) begin
            wait_tile(n);
            check($sformatf("row%0d_data", r), tile_data, make_tile(32'h100 + 32'h40 * r, 16));
            check($sformatf("row%0d_last", r), 256'(tile_last), 256'(r == 2));
        end
        @(negedge clk);
        check("rows_done", 256'(done), 256'(1));
        wait_idle();

        // Back-pressure on the first of two tiles
        tile_ready = 1'b0;
        send_cmd(32'h200, 40, 1, 0);
        wait_tile(n);
        check("hold_latency", 256'(n), 256'(10));
        for (int c = 0; c < 5; c++) begin
            check("hold_data", tile_data, make_tile(32'h200, 32));
            check("hold_rd_en", {tile_valid, mem_rd_en}, 256'(2'b10));
            @(negedge clk);
        end
        tile_ready = 1'b1;
        @(negedge clk);
        check("post_hs_prime", 256'(mem_rd_en), 256'(1));
        check("post_hs_addr", 256'(mem_addr), 256'(24'h220));
        wait_tile(n);
        check("hold_t2_data", tile_data, make_tile(32'h220, 8));
        wait_idle();

        // Zero length and zero rows complete without reads
        rd0 = rd_count;
        send_cmd(32'h100, 0, 4, 0);
        @(negedge clk);
        check("len0_done", 256'(done), 256'(1));
        send_cmd(32'h100, 8, 0, 0);
        @(negedge clk);
        check("rows0_done", 256'(done), 256'(1));
        @(negedge clk);
        check("zero_reads", 256'(rd_count - rd0), 256'(0));

        // Abort during READ
        dn0 = done_count; tv0 = tv_count;
        send_cmd(32'h300, 32, 1, 0);
        repeat (4) @(negedge clk);
        check("pre_abort_state", 256'(dbg_state), 256'(ST_READ));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle", {busy, tile_valid, mem_rd_en}, 256'(0));
        check("abort_ready", 256'(cmd_ready), 256'(1));
        rd0 = rd_count;
        repeat (15) @(negedge clk);
        check("abort_no_done", 256'(done_count - dn0), 256'(0));
        check("abort_no_tile", 256'(tv_count - tv0), 256'(0));
        check("abort_no_reads", 256'(rd_count - rd0), 256'(0));

        // Abort beats a same-cycle handshake on the final tile
        dn0 = done_count;
        send_cmd(32'h300, 32, 1, 0);
        wait_tile(n);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_hs_state", 256'(dbg_state), 256'(ST_IDLE));
        repeat (3) @(negedge clk);
        check("abort_hs_no_done", 256'(done_count - dn0), 256'(0));

        // Reset during READ, then accept on the first edge after release
        dn0 = done_count;
        send_cmd(32'h100, 32, 1, 0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_state", 256'(dbg_state), 256'(ST_IDLE));
        check("mid_rst_outputs", {busy, tile_valid, tile_last, done, mem_rd_en}, 256'(0));
        check("mid_rst_data", tile_data, 256'(0));
        check("mid_rst_addr", 256'(mem_addr), 256'(0));
        check("mid_rst_ready", 256'(cmd_ready), 256'(1));
        @(negedge clk);
        rst = 1'b0;
        cmd_addr = 24'h102; cmd_length = 20'd32; cmd_rows = 12'd1; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        check("rst_no_done", 256'(done_count - dn0), 256'(0));
        check("release_accept", 256'(busy), 256'(1));
        wait_tile(n);
        check("rel_latency", 256'(n), 256'(10));
        check("rel_aligned_data", tile_data, make_tile(32'h100, 32));
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tile_loader.md
TILE_LOADER -- requirements
Module: tile_loader

Interface
REQ-001 Parameters: TILE_WIDTH, 256, tile bits (multiple of BUS_BYTES*8); DATA_WIDTH, 8, element bits (8/16/32); BUS_BYTES, 4, bytes per memory beat; ADDR_WIDTH, 24, byte address bits.
REQ-002 clk  in  1  clock; rst  in  1  asynchronous, active-high reset.
REQ-003 cmd_valid in 1 command offered; cmd_ready out 1 command accepted when both high.
REQ-004 cmd_addr in ADDR_WIDTH first-row byte address; cmd_length in 20 elements per row; cmd_rows in 12 row count; cmd_stride in ADDR_WIDTH bytes between row starts.
REQ-005 abort in 1 cancels the active command.
REQ-006 mem_rd_en out 1 read strobe; mem_addr out ADDR_WIDTH beat address; mem_rdata in BUS_BYTES*8 data, valid one cycle after mem_rd_en.
REQ-007 tile_data out TILE_WIDTH packed tile; tile_valid out 1; tile_ready in 1; tile_last out 1 final tile of command.
REQ-008 done out 1 one-cycle completion pulse; busy out 1 high whenever not IDLE.

Function
REQ-009 BEATS = TILE_WIDTH/(BUS_BYTES*8); ROW_BYTES = cmd_length*DATA_WIDTH/8; TILES_PER_ROW = ceil(ROW_BYTES*8/TILE_WIDTH); all computed at acceptance with no truncation.
REQ-010 States IDLE, PRIME, READ, OUTPUT, DONE; cmd_ready = (state==IDLE); command fields latched on acceptance.
REQ-011 IDLE->PRIME on accept; if cmd_length==0 or cmd_rows==0, IDLE->DONE instead and no read is issued.
REQ-012 PRIME: mem_rd_en=1 at current beat address; ->READ.
REQ-013 READ: capture mem_rdata of the previous read while issuing the next; after BEATS captures ->OUTPUT with no further read issued.
REQ-014 Packing: first byte of a tile at tile_data[TILE_WIDTH-1 -: 8]; within a beat, lowest-address byte most significant.
REQ-015 Bytes at row offset >= ROW_BYTES are zero in tile_data, regardless of mem_rdata.
REQ-016 Each row starts a new tile; row r base = cmd_addr + r*cmd_stride, modulo 2^ADDR_WIDTH; within a row mem_addr advances by BUS_BYTES per beat.
REQ-017 cmd_addr and stride low log2(BUS_BYTES) bits are treated as zero.
REQ-018 OUTPUT: tile_valid=1; tile_data and tile_last held stable and mem_rd_en=0 until tile_ready; on handshake ->PRIME for next tile, or ->DONE after final tile.
REQ-019 With tile_ready held high, first tile_valid occurs exactly BEATS+2 cycles after acceptance; consecutive tiles BEATS+2 cycles apart.
REQ-020 tile_last = 1 only with the last tile of the last row.
REQ-021 DONE: done=1 for one cycle; ->IDLE.
REQ-022 abort in any non-IDLE state: next cycle state IDLE, tile_valid=0, mem_rd_en=0, no done pulse; abort has priority over handshake in the same cycle; abort in IDLE ignored.
REQ-023 cmd_valid while busy is not accepted (cmd_ready=0).

Reset
REQ-024 rst asserted: state IDLE; mem_rd_en, tile_valid, tile_last, done, busy = 0; mem_addr, tile_data, counters = 0; cmd_ready = 1.
REQ-025 rst mid-transfer discards the command with no done pulse; first accept possible on the first clock edge after release.

Structure
REQ-026 Shared package tinyml_load_pkg holds the state enum and BEATS/tile-count helper functions.
REQ-027 Memory is external; beat insertion and zero-fill masking live in one sub-module tile_packer.

Verification (defaults, memory byte at A = A[7:0])
REQ-028 addr 0x000100, length 32, rows 1, ready high -> one tile, tile_data[255:248]=0x00, [7:0]=0x1F; tile_valid at accept+10; tile_last=1; done next cycle.
REQ-029 length 40, rows 1 -> two tiles; second holds 0x20..0x27 in top 8 bytes, rest zero; tile_last only on second.
REQ-030 addr 0x100, length 16, rows 3, stride 0x40 -> three tiles from 0x100, 0x140, 0x180; lower 16 bytes of each zero.
REQ-031 tile_ready low 5 cycles on first tile -> tile_data stable, mem_rd_en=0 throughout hold; next PRIME cycle after handshake.
REQ-032 length 0 -> done one cycle after accept, no mem_rd_en; abort during READ -> IDLE next cycle, no done; rst during READ -> all outputs reset values.
